// File: rtl/elevator_open_door.sv
// Single-door controller: CLOSED -> OPENING -> OPEN -> CLOSING with a 16-bit dwell counter.
// Optional macro ELEVATOR_DOOR_OBSTRUCT_EN adds an obstruct input that re-opens or holds the door.
module elevator_open_door #(
    parameter int unsigned FLOOR       = 6,
    parameter int unsigned MOVE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES = 5
) (
    input  logic             clock,
    input  logic             reset,
`ifdef ELEVATOR_DOOR_OBSTRUCT_EN
    input  logic             obstruct,
`endif
    input  logic             open_req,
    input  logic [FLOOR-1:0] current_floor,
    output logic [FLOOR-1:0] door,
    output logic             door_closed,
    output logic             door_open
);

    typedef enum logic [1:0] {
        StClosed,
        StOpening,
        StOpen,
        StClosing
    } state_e;

    localparam logic [15:0]      MoveLoad = 16'(MOVE_CYCLES - 1);
    localparam logic [15:0]      HoldLoad = 16'(HOLD_CYCLES - 1);
    localparam logic [FLOOR-1:0] FloorMax = FLOOR'(FLOOR);
    localparam logic [FLOOR-1:0] OneLsb   = FLOOR'(1);

    state_e           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [FLOOR-1:0] floor_q, floor_d;
    logic [FLOOR-1:0] door_q, door_d;

    logic floor_ok;
    logic cnt_zero;
    logic hold_req;
    logic obs_active;

`ifdef ELEVATOR_DOOR_OBSTRUCT_EN
    assign obs_active = obstruct;
`else
    assign obs_active = 1'b0;
`endif

    assign floor_ok = (current_floor != '0) && (current_floor <= FloorMax);
    assign cnt_zero = (cnt_q == 16'd0);
    // Same-floor request (or obstruction) keeps the door open; beats expiry in the same cycle.
    assign hold_req = (open_req && (current_floor == floor_q)) || obs_active;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        floor_d = floor_q;
        door_d  = door_q;
        unique case (state_q)
            StClosed: begin
                if (open_req && floor_ok) begin
                    state_d = StOpening;
                    cnt_d   = MoveLoad;
                    floor_d = current_floor;
                    door_d  = OneLsb << (current_floor - OneLsb);
                end
            end
            StOpening: begin
                if (cnt_zero) begin
                    state_d = StOpen;
                    cnt_d   = HoldLoad;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StOpen: begin
                if (hold_req) begin
                    cnt_d = HoldLoad;
                end else if (cnt_zero) begin
                    state_d = StClosing;
                    cnt_d   = MoveLoad;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StClosing: begin
                if (obs_active) begin
                    state_d = StOpening;
                    cnt_d   = MoveLoad;
                end else if (cnt_zero) begin
                    state_d = StClosed;
                    door_d  = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = StClosed;
                cnt_d   = 16'd0;
                door_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StClosed;
            cnt_q   <= 16'd0;
            floor_q <= '0;
            door_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            floor_q <= floor_d;
            door_q  <= door_d;
        end
    end

    assign door        = door_q;
    assign door_closed = (state_q == StClosed);
    assign door_open   = (state_q == StOpen);

endmodule

// File: tb/tb_elevator_open_door.sv
// Directed bench for elevator_open_door: stimulus pushes expected outputs, a monitor pops and checks.
// Define ELEVATOR_DOOR_OBSTRUCT_EN to also exercise the obstruct input.
module tb_elevator_open_door;

    logic       clock         = 1'b0;
    logic       reset         = 1'b1;
    logic       open_req      = 1'b0;
    logic [5:0] current_floor = 6'd0;
`ifdef ELEVATOR_DOOR_OBSTRUCT_EN
    logic       obstruct      = 1'b0;
    logic       obs_next      = 1'b0;
`endif
    logic [5:0] door;
    logic       door_closed;
    logic       door_open;

    logic [7:0] exp_q[$];
    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    elevator_open_door #(
        .FLOOR       (6),
        .MOVE_CYCLES (2),
        .HOLD_CYCLES (5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
`ifdef ELEVATOR_DOOR_OBSTRUCT_EN
        .obstruct      (obstruct),
`endif
        .open_req      (open_req),
        .current_floor (current_floor),
        .door          (door),
        .door_closed   (door_closed),
        .door_open     (door_open)
    );

    // Inputs set at negedge; expectation is for the outputs after the following posedge.
    task automatic cyc(input logic r, input logic rq, input logic [5:0] fl,
                       input logic [5:0] ed, input logic ec, input logic eo);
        @(negedge clock);
        reset         = r;
        open_req      = rq;
        current_floor = fl;
`ifdef ELEVATOR_DOOR_OBSTRUCT_EN
        obstruct      = obs_next;
`endif
        exp_q.push_back({ed, ec, eo});
    endtask

    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compared++;
                if ({door, door_closed, door_open} !== e) begin
                    mismatched++;
                    $display("FAIL cycle %0d: door/closed/open got %b/%b/%b want %b/%b/%b",
                             compared, door, door_closed, door_open, e[7:2], e[1], e[0]);
                end
            end
        end
    end

    localparam logic [5:0] Z  = 6'b000000;
    localparam logic [5:0] F1 = 6'b000001;
    localparam logic [5:0] F2 = 6'b000010;
    localparam logic [5:0] F3 = 6'b000100;
    localparam logic [5:0] F4 = 6'b001000;
    localparam logic [5:0] F5 = 6'b010000;
    localparam logic [5:0] F6 = 6'b100000;

    initial begin : stimulus
        // Reset state, with a request present that must be overridden
        cyc(1'b1, 1'b0, 6'd0, Z, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 6'd3, Z, 1'b1, 1'b0);

        // Floor 3, plain 2+5+2 cycle, accepted on first edge after reset
        cyc(1'b0, 1'b1, 6'd3, F3, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 6'd3, F3, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 6'd3, F3, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 6'd3, F3, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 6'd3, Z, 1'b1, 1'b0);

        // Out-of-range floors ignored
        cyc(1'b0, 1'b1, 6'd0, Z, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 6'd7, Z, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 6'd63, Z, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 6'd0, Z, 1'b1, 1'b0);

        // Floor 6, re-request on entry to 3rd OPEN cycle: OPEN lasts 7
        cyc(1'b0, 1'b1, 6'd6, F6, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 6'd6, F6, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 6'd6, F6, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 6'd6, F6, 1'b0, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 6'd6, F6, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 6'd6, F6, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 6'd6, Z, 1'b1, 1'b0);

        // Floor 2, then requests for floor 5 throughout: no effect, even on the closing edge
        cyc(1'b0, 1'b1, 6'd2, F2, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 6'd5, F2, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b1, 6'd5, F2, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 1'b1, 6'd5, F2, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 6'd5, Z, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 6'd0, Z, 1'b1, 1'b0);

        // Floor 5, hold extend on the expiry edge wins over closing
        cyc(1'b0, 1'b1, 6'd5, F5, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 6'd5, F5, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 6'd5, F5, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 6'd5, F5, 1'b0, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 6'd5, F5, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 6'd5, F5, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 6'd5, Z, 1'b1, 1'b0);

        // Floor 4, reset during OPEN, then floor 1
        cyc(1'b0, 1'b1, 6'd4, F4, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 6'd4, F4, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 6'd4, F4, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 6'd4, Z, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 6'd1, F1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 6'd1, F1, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 6'd1, F1, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 6'd1, F1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 6'd1, Z, 1'b1, 1'b0);

`ifdef ELEVATOR_DOOR_OBSTRUCT_EN
        // Floor 5, obstruction after 1st CLOSING cycle re-opens for a full sequence
        cyc(1'b0, 1'b1, 6'd5, F5, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 6'd5, F5, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 6'd5, F5, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 6'd5, F5, 1'b0, 1'b0);
        obs_next = 1'b1;
        cyc(1'b0, 1'b0, 6'd5, F5, 1'b0, 1'b0);
        obs_next = 1'b0;
        cyc(1'b0, 1'b0, 6'd5, F5, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 6'd5, F5, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 6'd5, F5, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 6'd5, Z, 1'b1, 1'b0);
`endif

        repeat (3) @(negedge clock);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/elevator_open_door.md
ELEVATOR_OPEN_DOOR -- requirements
Module: elevator_open_door

Interface
REQ-001 Parameter FLOOR, default 6: number of served floors; door vector width.
REQ-002 Parameter MOVE_CYCLES, default 2: cycles spent in OPENING and in CLOSING, range 1..65535.
REQ-003 Parameter HOLD_CYCLES, default 5: cycles spent fully open, range 1..65535.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 open_req  input  1  level request to open the door at current_floor, sampled each rising edge.
REQ-007 current_floor  input  FLOOR  binary floor number, valid range 1..FLOOR.
REQ-008 door  output  FLOOR  one-hot door-not-closed vector; bit n-1 set = door at floor n not fully closed.
REQ-009 door_closed  output  1  high only in state CLOSED.
REQ-010 door_open  output  1  high only in state OPEN.

Function
REQ-011 The block SHALL implement a four-state FSM: CLOSED, OPENING, OPEN, CLOSING, plus a 16-bit down-counter.
REQ-012 CLOSED: open_req=1 with 1<=current_floor<=FLOOR SHALL latch the floor and enter OPENING next cycle with counter=MOVE_CYCLES-1.
REQ-013 CLOSED: open_req with current_floor=0 or >FLOOR SHALL be ignored; state stays CLOSED, door stays 0.
REQ-014 OPENING: counter decrements each cycle; at counter=0 SHALL enter OPEN with counter=HOLD_CYCLES-1.
REQ-015 OPEN: counter decrements; at counter=0 SHALL enter CLOSING with counter=MOVE_CYCLES-1.
REQ-016 OPEN: open_req=1 with current_floor equal to the latched floor SHALL reload counter to HOLD_CYCLES-1 (hold extend); takes priority over expiry in the same cycle.
REQ-017 CLOSING: counter decrements; at counter=0 SHALL enter CLOSED.
REQ-018 CLOSING: open_req SHALL be ignored; a new request is accepted only once CLOSED.
REQ-019 Requests naming a floor different from the latched floor outside CLOSED SHALL be ignored, not queued.
REQ-020 door SHALL equal 1<<(latched_floor-1) in OPENING, OPEN, CLOSING and 0 in CLOSED; door is registered (changes on the edge that changes state).
REQ-021 Changes of current_floor after acceptance SHALL NOT affect door or timing.
REQ-022 Total door cycle without extension SHALL be 2*MOVE_CYCLES+HOLD_CYCLES cycles from first non-CLOSED cycle to return to CLOSED.

Reset
REQ-023 reset=1 at a rising edge SHALL force CLOSED, counter=0, latched floor=0, door=0, door_closed=1, door_open=0, overriding all other inputs, including mid-cycle.
REQ-024 First request is accepted on the first edge after reset deasserts.

Configuration
REQ-025 Macro ELEVATOR_DOOR_OBSTRUCT_EN, when defined, SHALL add input obstruct (1 bit, active-high).
REQ-026 With the macro: obstruct=1 in CLOSING SHALL enter OPENING next cycle, counter=MOVE_CYCLES-1, same latched floor; obstruct=1 in OPEN SHALL reload counter to HOLD_CYCLES-1; obstruct ignored in CLOSED and OPENING.
REQ-027 Without the macro: no obstruct port; CLOSING always runs to CLOSED.

Verification
REQ-028 Reset, then open_req=1 one cycle, current_floor=3 -> door=6'b000100 for exactly 9 cycles (2 OPENING, 5 OPEN, 2 CLOSING), door_open high 5 cycles, then door=0, door_closed=1.
REQ-029 open_req with current_floor=0, then 7 -> door stays 0, door_closed stays 1.
REQ-030 Floor 6 request, re-assert open_req at floor 6 on 3rd OPEN cycle -> OPEN lasts 7 cycles, total 11 cycles of door=6'b100000.
REQ-031 Floor 2 accepted, current_floor switched to 5 with open_req during OPEN and CLOSING -> door stays 6'b000010, no extension, closes after 9 cycles.
REQ-032 reset asserted during OPEN of floor 4 -> next edge door=0, door_closed=1; new request floor 1 then yields door=6'b000001.
REQ-033 With ELEVATOR_DOOR_OBSTRUCT_EN: floor 5, obstruct=1 on 1st CLOSING cycle -> OPENING again, door=6'b010000 held, full 2+5+2 sequence repeats before CLOSED.
